// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: start + DATA_BITS (LSB first) + STOP_BITS UART framer with an internal baud divider
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_uart,
  input  logic [7:0] w_data,
  output logic       tx_busy,
  output logic       tx,
  output logic       tx_done_tick
);
  localparam int BW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         state;
  logic [BW-1:0]  baud;
  logic [2:0]     idx;
  logic [7:0]     sr;
  logic           bit_end;
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  // tx is registered: each bit's level is loaded on the boundary edge that begins it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      baud         <= '0;
      idx          <= '0;
      sr           <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      baud         <= bit_end ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          baud <= '0;
          if (wr_uart && !tx_busy) begin
            state   <= START;
            sr      <= w_data;
            idx     <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= sr[0];
          sr    <= sr >> 1;
        end
        DATA: if (bit_end) begin
          if (idx == 3'(DATA_BITS - 1)) begin
            state <= STOP;
            idx   <= '0;
            tx    <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
            tx  <= sr[0];
            sr  <= sr >> 1;
          end
        end
        STOP: if (bit_end) begin
          if (idx == 3'(STOP_BITS - 1)) begin
            state        <= IDLE;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end
endmodule
